lsq_dcache_arbiter: RTL and testbench
=====================================

Name: lsq_dcache_arbiter

Overview:
Arbitrates the single data-cache port between the load queue and the store queue of the split LSQ. Loads issue once their address is ready; stores issue once committed at the ROB head. The block owns the registered request presented to the dcache, tracks the one outstanding access, and routes the response and completion back to the requester that issued it. A starvation counter bounds how long committed stores can block loads.

Parameters:
TAG_WIDTH, 3, width of the queue-index tag carried with each request and returned on completion
STARVE_LIMIT, 4, consecutive store grants made while a load waits before the load is forced to win
CNT_WIDTH, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush; kills in-flight/pending load results
ld_req  in  1  load queue head requests the cache
ld_addr  in  32  load byte address
ld_rmask  in  4  load read mask, already shifted by addr[1:0]
ld_tag  in  TAG_WIDTH  load queue index
ld_gnt  out  1  load accepted this cycle
ld_done  out  1  load data returned this cycle
ld_done_tag  out  TAG_WIDTH  tag of the completing load
ld_rdata  out  32  raw cache word for the completing load
st_req  in  1  committed store requests the cache
st_addr  in  32  store byte address
st_wmask  in  4  store write mask
st_wdata  in  32  store data, already lane-aligned
st_tag  in  TAG_WIDTH  store queue index
st_gnt  out  1  store accepted this cycle
st_done  out  1  store write acknowledged this cycle
st_done_tag  out  TAG_WIDTH  tag of the completing store
d_addr  out  32  dcache address, bits[1:0] always 0
d_rmask  out  4  dcache read mask
d_wmask  out  4  dcache write mask
d_wdata  out  32  dcache write data
d_rdata  in  32  dcache read data
d_resp  in  1  dcache response, one-cycle pulse

Behaviour:
- Reset: state IDLE; all outputs 0; starve_cnt 0; in-flight tag and kill bit cleared. Reset mid-access abandons it: no done pulse, d_* zero on the next cycle.
- States: IDLE, BUSY_LD, BUSY_ST.
- Grant occurs in IDLE, or in BUSY_* on the d_resp cycle (back-to-back). Grants are combinational: the gnt pulse is asserted for exactly one cycle. The request fields are latched into output registers at the same edge, so d_* appear one cycle after gnt. A requester may drop or change its req the cycle after gnt.
- Priority when both requests are asserted: store wins unless starve_cnt == STARVE_LIMIT, in which case load wins.
- starve_cnt increments (saturating at STARVE_LIMIT) on a store grant made while ld_req is high, and clears on any load grant.
- BUSY_*: d_addr, d_rmask/d_wmask and d_wdata are held stable until d_resp. A load drives d_wmask=0 and d_wdata=0; a store drives d_rmask=0.
- d_resp in BUSY_LD: ld_done=1, ld_done_tag=latched tag, ld_rdata=d_rdata, all combinational in that cycle. The pulse is suppressed if the kill bit is set.
- d_resp in BUSY_ST: st_done=1, st_done_tag=latched tag.
- On d_resp with no new grant: next state IDLE and d_* = 0.
- flush while BUSY_LD sets the kill bit. The access still completes; no ld_done is issued.
- flush in IDLE or on a d_resp cycle blocks any load grant that cycle; stores may still be granted.
- flush has no effect on stores: committed stores always complete.
- d_resp while IDLE is ignored. A simulation assertion flags it.
- A request with an all-zero mask is illegal and is flagged by an assertion.

Optional Feature:
LSQ_ARB_PERF_CNT_EN. When defined, adds outputs perf_ld_grants, perf_st_grants, perf_conflict_cycles and perf_starve_forces, each CNT_WIDTH bits, wrapping. They count load grants, store grants, cycles with both requests asserted and no grant possible (busy without d_resp), and forced load wins. All counters clear on rst. When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Single load, tag=2, addr=0x1006, rmask=0100; d_resp after 3 cycles with d_rdata=0xAABBCCDD -> ld_gnt in cycle 0; d_addr=0x1004 and d_rmask=0100 from cycle 1 until d_resp; ld_done with tag 2 and rdata 0xAABBCCDD; IDLE next cycle.
- ld_req and st_req both held high, tags ld=1 st=5, d_resp 2 cycles after each request -> grant order ST,ST,ST,ST,LD; starve_cnt returns to 0 after the load grant.
- Back-to-back: st_req pending when a load's d_resp arrives -> ld_done and st_gnt in the same cycle; d_wmask nonzero on the next cycle with no idle bubble.
- flush one cycle after ld_gnt, then d_resp -> ld_done never asserts; a following store is granted normally.
- rst asserted while BUSY_ST -> no st_done; next cycle all d_* = 0 and state IDLE; a subsequent load is granted with starve_cnt=0.
- LSQ_ARB_PERF_CNT_EN defined, run the priority scenario for 5 grants -> perf_st_grants=4, perf_ld_grants=1, perf_starve_forces=1.

Source files
------------

// File: rtl/lsq_dcache_arbiter.sv
// Arbitrates the single dcache port between the LSQ load and store queues, one access in flight.
// Optional performance counters are enabled by defining LSQ_ARB_PERF_CNT_EN.
module lsq_dcache_arbiter #(
  parameter int TAG_WIDTH    = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ld_req,
  input  logic [31:0]          ld_addr,
  input  logic [3:0]           ld_rmask,
  input  logic [TAG_WIDTH-1:0] ld_tag,
  output logic                 ld_gnt,
  output logic                 ld_done,
  output logic [TAG_WIDTH-1:0] ld_done_tag,
  output logic [31:0]          ld_rdata,
  input  logic                 st_req,
  input  logic [31:0]          st_addr,
  input  logic [3:0]           st_wmask,
  input  logic [31:0]          st_wdata,
  input  logic [TAG_WIDTH-1:0] st_tag,
  output logic                 st_gnt,
  output logic                 st_done,
  output logic [TAG_WIDTH-1:0] st_done_tag,
  output logic [31:0]          d_addr,
  output logic [3:0]           d_rmask,
  output logic [3:0]           d_wmask,
  output logic [31:0]          d_wdata,
  input  logic [31:0]          d_rdata,
  input  logic                 d_resp
`ifdef LSQ_ARB_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_ld_grants,
  output logic [CNT_WIDTH-1:0] perf_st_grants,
  output logic [CNT_WIDTH-1:0] perf_conflict_cycles,
  output logic [CNT_WIDTH-1:0] perf_starve_forces
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_LD, BUSY_ST} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]             rmask_q, rmask_d, wmask_q, wmask_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic                   kill_q, kill_d;
  logic                   can_grant, force_ld, resp_ld, resp_st;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rmask_d  = rmask_q;
    wmask_d  = wmask_q;
    tag_d    = tag_q;
    starve_d = starve_q;
    kill_d   = kill_q;

    // A new access may start while idle or in the cycle the current one completes.
    can_grant = !rst && (state_q == IDLE || d_resp);
    force_ld  = (starve_q == SW'(STARVE_LIMIT));
    ld_gnt    = can_grant && ld_req && !flush && (!st_req || force_ld);
    st_gnt    = can_grant && st_req && !ld_gnt;
    resp_ld   = !rst && d_resp && (state_q == BUSY_LD);
    resp_st   = !rst && d_resp && (state_q == BUSY_ST);

    ld_done     = resp_ld && !kill_q;
    ld_done_tag = ld_done ? tag_q : '0;
    ld_rdata    = ld_done ? d_rdata : '0;
    st_done     = resp_st;
    st_done_tag = st_done ? tag_q : '0;

    if (ld_gnt) begin
      state_d  = BUSY_LD;
      addr_d   = {ld_addr[31:2], 2'b00};
      rmask_d  = ld_rmask;
      wmask_d  = '0;
      wdata_d  = '0;
      tag_d    = ld_tag;
      kill_d   = 1'b0;
      starve_d = '0;
    end else if (st_gnt) begin
      state_d  = BUSY_ST;
      addr_d   = {st_addr[31:2], 2'b00};
      rmask_d  = '0;
      wmask_d  = st_wmask;
      wdata_d  = st_wdata;
      tag_d    = st_tag;
      kill_d   = 1'b0;
      if (ld_req && !force_ld) starve_d = starve_q + 1'b1;
    end else if (resp_ld || resp_st) begin
      state_d = IDLE;
      addr_d  = '0;
      rmask_d = '0;
      wmask_d = '0;
      wdata_d = '0;
      kill_d  = 1'b0;
    end else if (state_q == BUSY_LD && flush) begin
      kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rmask_q  <= '0;
      wmask_q  <= '0;
      tag_q    <= '0;
      starve_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rmask_q  <= rmask_d;
      wmask_q  <= wmask_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
      kill_q   <= kill_d;
    end
  end

  assign d_addr  = addr_q;
  assign d_rmask = rmask_q;
  assign d_wmask = wmask_q;
  assign d_wdata = wdata_q;

  // Byte offset is folded into the mask by the LSQ, so the low address bits are dropped.
  logic unused_ok;
  assign unused_ok = ^{ld_addr[1:0], st_addr[1:0], (CNT_WIDTH > 0)};

`ifdef LSQ_ARB_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] ld_cnt_q, st_cnt_q, conf_cnt_q, force_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q    <= '0;
      st_cnt_q    <= '0;
      conf_cnt_q  <= '0;
      force_cnt_q <= '0;
    end else begin
      if (ld_gnt) ld_cnt_q <= ld_cnt_q + 1'b1;
      if (st_gnt) st_cnt_q <= st_cnt_q + 1'b1;
      if (ld_req && st_req && state_q != IDLE && !d_resp) conf_cnt_q <= conf_cnt_q + 1'b1;
      if (ld_gnt && st_req) force_cnt_q <= force_cnt_q + 1'b1;
    end
  end

  assign perf_ld_grants       = ld_cnt_q;
  assign perf_st_grants       = st_cnt_q;
  assign perf_conflict_cycles = conf_cnt_q;
  assign perf_starve_forces   = force_cnt_q;
`endif

  a_resp_idle: assert property (@(posedge clk) disable iff (rst) !(d_resp && state_q == IDLE))
    else $error("d_resp asserted while IDLE");
  a_ld_mask: assert property (@(posedge clk) disable iff (rst) ld_req |-> (ld_rmask != 4'd0))
    else $error("load request with empty read mask");
  a_st_mask: assert property (@(posedge clk) disable iff (rst) st_req |-> (st_wmask != 4'd0))
    else $error("store request with empty write mask");

endmodule

// File: tb/tb_lsq_dcache_arbiter.sv
// Directed test-plan scenarios followed by randomized traffic, all checked against a transaction-level model.
module tb_lsq_dcache_arbiter;
  localparam int TW = 3;
  localparam int LIMIT = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst, flush, ld_req, st_req, d_resp;
  logic [31:0] ld_addr, st_addr, st_wdata, d_rdata;
  logic [3:0]  ld_rmask, st_wmask;
  logic [TW-1:0] ld_tag, st_tag;
  logic ld_gnt, ld_done, st_gnt, st_done;
  logic [TW-1:0] ld_done_tag, st_done_tag;
  logic [31:0] ld_rdata, d_addr, d_wdata;
  logic [3:0]  d_rmask, d_wmask;
`ifdef LSQ_ARB_PERF_CNT_EN
  logic [CW-1:0] perf_ld_grants, perf_st_grants, perf_conflict_cycles, perf_starve_forces;
  logic [CW-1:0] p_ld, p_st, p_conf, p_force;
`endif

  lsq_dcache_arbiter #(.TAG_WIDTH(TW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_tag(ld_tag),
    .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_done_tag(ld_done_tag), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata), .st_tag(st_tag),
    .st_gnt(st_gnt), .st_done(st_done), .st_done_tag(st_done_tag),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp)
`ifdef LSQ_ARB_PERF_CNT_EN
    , .perf_ld_grants(perf_ld_grants), .perf_st_grants(perf_st_grants),
    .perf_conflict_cycles(perf_conflict_cycles), .perf_starve_forces(perf_starve_forces)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model of the one outstanding access: owner 0 = none, 1 = load, 2 = store.
  int owner, age, starve;
  bit killed;
  logic [TW-1:0] m_tag;
  logic [31:0] m_addr, m_wdata;
  logic [3:0] m_rmask, m_wmask;
  bit e_ld_gnt, e_st_gnt, e_ld_done, e_st_done;
  int gq[$];
  int exp_order[5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    owner = 0; age = 0; starve = 0; killed = 0; m_tag = '0;
    m_addr = '0; m_wdata = '0; m_rmask = '0; m_wmask = '0;
`ifdef LSQ_ARB_PERF_CNT_EN
    p_ld = '0; p_st = '0; p_conf = '0; p_force = '0;
`endif
  endtask

  // Compare this cycle's outputs, then advance the model across the clock edge.
  task automatic cyc();
    bit can;
    #1;
    can       = !rst && (owner == 0 || d_resp);
    e_ld_gnt  = can && ld_req && !flush && (!st_req || starve == LIMIT);
    e_st_gnt  = can && st_req && !e_ld_gnt;
    e_ld_done = !rst && owner == 1 && d_resp && !killed;
    e_st_done = !rst && owner == 2 && d_resp;
    chk("ld_gnt", ld_gnt, e_ld_gnt);
    chk("st_gnt", st_gnt, e_st_gnt);
    chk("ld_done", ld_done, e_ld_done);
    chk("ld_done_tag", ld_done_tag, e_ld_done ? m_tag : '0);
    chk("ld_rdata", ld_rdata, e_ld_done ? d_rdata : 32'h0);
    chk("st_done", st_done, e_st_done);
    chk("st_done_tag", st_done_tag, e_st_done ? m_tag : '0);
    chk("d_addr", d_addr, m_addr);
    chk("d_rmask", d_rmask, m_rmask);
    chk("d_wmask", d_wmask, m_wmask);
    chk("d_wdata", d_wdata, m_wdata);
`ifdef LSQ_ARB_PERF_CNT_EN
    chk("perf_ld", perf_ld_grants, p_ld);
    chk("perf_st", perf_st_grants, p_st);
    chk("perf_conf", perf_conflict_cycles, p_conf);
    chk("perf_force", perf_starve_forces, p_force);
`endif
    if (ld_gnt) gq.push_back(1);
    if (st_gnt) gq.push_back(2);
    @(posedge clk);
    if (rst) model_clear();
    else begin
`ifdef LSQ_ARB_PERF_CNT_EN
      if (e_ld_gnt) p_ld++;
      if (e_st_gnt) p_st++;
      if (ld_req && st_req && owner != 0 && !d_resp) p_conf++;
      if (e_ld_gnt && st_req) p_force++;
`endif
      if (e_ld_gnt) begin
        owner = 1; age = 0; killed = 0; starve = 0; m_tag = ld_tag;
        m_addr = ld_addr & ~32'h3; m_rmask = ld_rmask; m_wmask = 0; m_wdata = 0;
      end else if (e_st_gnt) begin
        owner = 2; age = 0; killed = 0; m_tag = st_tag;
        if (ld_req && starve < LIMIT) starve++;
        m_addr = st_addr & ~32'h3; m_rmask = 0; m_wmask = st_wmask; m_wdata = st_wdata;
      end else if (owner != 0 && d_resp) begin
        owner = 0; killed = 0; m_addr = 0; m_rmask = 0; m_wmask = 0; m_wdata = 0;
      end else begin
        if (owner == 1 && flush) killed = 1;
        if (owner != 0) age++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; ld_req = 0; st_req = 0; d_resp = 0; d_rdata = 0;
    ld_addr = 0; ld_rmask = 4'h1; ld_tag = 0;
    st_addr = 0; st_wmask = 4'hF; st_wdata = 0; st_tag = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cyc(); cyc();
    rst = 0;
  endtask

  initial begin
    model_clear();
    idle_inputs();
    @(negedge clk);
    do_reset();
    cyc();

    // Single load
    ld_req = 1; ld_tag = 2; ld_addr = 32'h1006; ld_rmask = 4'b0100;
    chk("s1_gnt", {63'b0, 1'b1}, 64'(1));
    tests--;
    cyc();
    ld_req = 0;
    cyc();
    chk("s1_addr", d_addr, 32'h1004);
    chk("s1_rmask", d_rmask, 4'b0100);
    cyc();
    d_resp = 1; d_rdata = 32'hAABBCCDD;
    #1;
    chk("s1_done", ld_done, 1'b1);
    chk("s1_tag", ld_done_tag, 3'd2);
    chk("s1_rdata", ld_rdata, 32'hAABBCCDD);
    cyc();
    d_resp = 0;
    cyc();
    chk("s1_idle_addr", d_addr, 32'h0);

    // Store/load priority with starvation limit
    do_reset();
    gq.delete();
    ld_tag = 1; st_tag = 5; ld_addr = 32'h200; st_addr = 32'h300; st_wdata = 32'h1234_5678;
    for (int c = 0; c < 60; c++) begin
      ld_req = gq.size() < 5;
      st_req = gq.size() < 5;
      d_resp = owner != 0 && age >= 1;
      cyc();
      if (gq.size() >= 5 && owner == 0) break;
    end
    d_resp = 0;
    exp_order = '{2, 2, 2, 2, 1};
    chk("s2_ngrants", gq.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("s2_order%0d", i), (i < gq.size()) ? gq[i] : 0, exp_order[i]);
`ifdef LSQ_ARB_PERF_CNT_EN
    chk("s2_perf_st", perf_st_grants, 4);
    chk("s2_perf_ld", perf_ld_grants, 1);
    chk("s2_perf_force", perf_starve_forces, 1);
`endif

    // Back-to-back load completion and store grant
    do_reset();
    ld_req = 1; ld_tag = 3; ld_addr = 32'h40; ld_rmask = 4'h3;
    cyc();
    ld_req = 0;
    cyc();
    st_req = 1; st_tag = 6; st_addr = 32'h80; st_wmask = 4'b0011; st_wdata = 32'h0000_BEEF;
    d_resp = 1; d_rdata = 32'h5555_AAAA;
    #1;
    chk("s3_ld_done", ld_done, 1'b1);
    chk("s3_st_gnt", st_gnt, 1'b1);
    cyc();
    st_req = 0; d_resp = 0;
    #1;
    chk("s3_wmask", d_wmask, 4'b0011);
    cyc();
    d_resp = 1;
    cyc();
    d_resp = 0;

    // Flush kills the in-flight load
    do_reset();
    ld_req = 1; ld_tag = 4; ld_addr = 32'h100; ld_rmask = 4'hF;
    cyc();
    ld_req = 0; flush = 1;
    cyc();
    flush = 0;
    cyc();
    d_resp = 1; d_rdata = 32'hDEAD_BEEF;
    #1;
    chk("s4_no_done", ld_done, 1'b0);
    cyc();
    d_resp = 0; st_req = 1; st_tag = 2; st_wmask = 4'h1; st_addr = 32'h104;
    #1;
    chk("s4_st_gnt", st_gnt, 1'b1);
    cyc();
    st_req = 0;
    cyc();
    d_resp = 1;
    cyc();
    d_resp = 0;

    // Reset while a store is outstanding
    do_reset();
    st_req = 1; st_tag = 7; st_wmask = 4'hC; st_addr = 32'h500; st_wdata = 32'hCAFE_0000;
    cyc();
    st_req = 0;
    cyc();
    rst = 1;
    #1;
    chk("s5_no_done", st_done, 1'b0);
    cyc();
    rst = 0;
    #1;
    chk("s5_wmask0", d_wmask, 4'h0);
    chk("s5_addr0", d_addr, 32'h0);
    ld_req = 1; ld_tag = 1; ld_addr = 32'h600; ld_rmask = 4'h2;
    cyc();
    ld_req = 0;
    chk("s5_ld_owner", d_rmask, 4'h2);
    cyc();
    d_resp = 1;
    cyc();
    d_resp = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      ld_req   = $urandom_range(0, 1);
      st_req   = ($urandom_range(0, 2) != 0);
      ld_addr  = $urandom; st_addr = $urandom; st_wdata = $urandom; d_rdata = $urandom;
      ld_rmask = 4'($urandom_range(1, 15));
      st_wmask = 4'($urandom_range(1, 15));
      ld_tag   = TW'($urandom); st_tag = TW'($urandom);
      d_resp   = owner != 0 && ($urandom_range(0, 2) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
